intan_batch_packetizer: RTL and testbench
=========================================

Name: intan_batch_packetizer

Overview:
- Parametrised successor to the fixed-size RHD/RHS acquisition framing.
- Takes a non-stallable per-channel sample stream from the SPI engine and commits only whole frames to an internal FIFO.
- Emits AXI4-Stream packets of cfg_batch frames toward the DMA. Each frame is prefixed with a 64-bit magic number and a 32-bit timestamp.
- Adds features the fixed-size version lacks: channel count as a parameter, runtime batch size, whole-frame drop with counting, short-frame rollback, clean packet close on stop, and loopback pattern.

Parameters:
N_CH, 32, samples per frame (≥2)
DATA_W, 32, sample/output word width
FIFO_DEPTH, 256, sample FIFO words (power of 2, ≥ N_CH)
DESC_DEPTH, 8, frame-descriptor FIFO entries (power of 2)
BATCH_W, 8, width of cfg_batch
MAGIC, 64'hD7A22AAA38132A53, frame header magic (LO word sent first)

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s_tdata  in  DATA_W  sample
s_tvalid  in  1  sample strobe; no backpressure
s_tuser  in  1  first sample of frame (channel 0)
m_tdata  out  DATA_W  packet word
m_tvalid  out  1  AXIS valid
m_tready  in  1  AXIS ready
m_tlast  out  1  last word of packet
cfg_enable  in  1  session run
cfg_batch  in  BATCH_W  frames per packet; 0 treated as 1
cfg_loopback  in  1  replace samples with test pattern
stat_drop_cnt  out  16  frames dropped for lack of space; saturating
stat_err_cnt  out  16  short/malformed frames; saturating
stat_busy  out  1  frame in progress, packet open, or FIFO non-empty

Behaviour:
- Single clock aclk; aresetn asynchronous, active-low.
- Reset clears all pointers, counters, FSMs and stats; m_tvalid=0, m_tlast=0, m_tdata=0, stat_busy=0.

Write side: states W_IDLE / W_FRAME / W_SKIP.
- s_tvalid&s_tuser with cfg_enable=1:
  - If free sample words ≥ N_CH and a descriptor slot is free (counting the pending one): set tentative ptr = commit ptr, write sample 0, go to W_FRAME with idx=1.
  - Otherwise increment stat_drop_cnt and go to W_SKIP.
- Every frame start (accepted or dropped) increments the 32-bit wrapping timestamp. The timestamp zeroes on the cfg_enable rising edge.
- W_FRAME: each s_tvalid writes at tentative ptr. On idx==N_CH-1: commit ptr ← tentative+1, build descriptor {timestamp, last}, return to W_IDLE.
- s_tuser during W_FRAME before idx==N_CH-1: stat_err_cnt++, roll tentative ptr back to commit ptr, then treat this beat as a new frame start in the same cycle.
- s_tvalid without s_tuser in W_IDLE: ignored. In W_SKIP: discarded until the next s_tuser.
- cfg_enable falling mid-frame: the frame completes normally. New frame starts are ignored while disabled.
- Loopback: the written word is {frame_ts[15:0], idx[15:0]}, zero-extended or truncated to DATA_W.

Batching:
- cfg_batch is latched at the first committed frame of a packet.
- fcnt counts committed frames in the packet; last=1 when fcnt+1==latched batch, then fcnt resets.
- The descriptor of the most recent frame is held pending. It is pushed when the next frame commits, or immediately if its last=1.
- If cfg_enable=0, no frame is in progress, and a pending descriptor exists: push it with last forced to 1 (short packet).
- Dropped frames and rolled-back frames do not count toward the batch.

Read side: states R_IDLE → R_MAG_LO → R_MAG_HI → R_TS → R_DATA(N_CH beats) → R_IDLE.
- Leaves R_IDLE only when the descriptor FIFO is non-empty. Data for that frame is then guaranteed committed.
- Output is registered. A beat advances only on m_tvalid&m_tready, and data/last are held stable while stalled.
- m_tlast=1 only on the final R_DATA beat of a descriptor with last=1.
- The next frame's MAG_LO may follow with zero bubble.

Simultaneous events:
- Read and write on the same cycle are allowed.
- Free-space checks use the commit ptr and the current read ptr.

Decomposition:
- Package intan_pkg holds MAGIC_DEFAULT, the read-state enum, a desc_t struct {ts[31:0], last}, and a sat_inc function.
- One sub-module, intan_sync_fifo: a parametrised RAM FIFO with tentative/commit write pointers and a rollback input. It is instanced for samples; the descriptor FIFO is a plain instance with commit tied per push.

Test Plan:
- N_CH=4, cfg_batch=2, 4 frames of samples 0x10..0x1F, m_tready=1 -> 2 packets of 14 words (MAG_LO, MAG_HI, ts, 4 samples per frame); ts 0,1 then 2,3; tlast on words 14 and 28.
- cfg_batch=3, drop cfg_enable after frame 1 of a packet -> packet closes after 7 words with tlast=1; stat_busy falls to 0 once drained.
- m_tready=0 held, FIFO_DEPTH=8, N_CH=4, 4 frames -> frames 0,1 stored, frames 2,3 dropped, stat_drop_cnt=2; release -> ts of output frames are 0,1.
- s_tuser reasserted after 2 samples -> stat_err_cnt=1; partial frame absent; following frame output intact with ts=1.
- cfg_loopback=1, N_CH=4 -> frame ts=5 samples 0x00050000..0x00050003.
- aresetn pulsed low mid-packet with m_tready toggling -> m_tvalid=0 asynchronously; after release the next packet starts at MAG_LO with ts=0 and counters at 0.

Source files
------------

// File: rtl/intan_pkg.sv
// Shared types and helpers for the Intan batch packetizer.
// Holds the default frame magic, FSM state enums, the frame descriptor and a saturating counter step.
package intan_pkg;

    localparam logic [63:0] MAGIC_DEFAULT = 64'hD7A22AAA38132A53;

    typedef enum logic [2:0] {
        R_IDLE,
        R_MAG_LO,
        R_MAG_HI,
        R_TS,
        R_DATA
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FRAME,
        W_SKIP
    } wstate_e;

    typedef struct packed {
        logic [31:0] ts;
        logic        last;
    } desc_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/intan_sync_fifo.sv
// RAM FIFO with a tentative write pointer that only becomes readable on commit.
// Ports: wr_en/wr_data write at the tentative pointer (or at the commit pointer when
// rollback is high), commit publishes everything written so far, rd_en pops,
// rd_data/empty/used describe committed contents only.
module intan_sync_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rollback,
    input  logic         commit,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic [AW:0]  used
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  cptr_q, cptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [AW:0]  wbase;

    // Rollback and a write in the same cycle restart the frame at the commit point.
    always_comb begin
        wbase  = rollback ? cptr_q : wptr_q;
        wptr_d = wbase + {{AW{1'b0}}, wr_en};
        cptr_d = commit ? wptr_d : cptr_q;
        rptr_d = rptr_q + {{AW{1'b0}}, rd_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            cptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            cptr_q <= cptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wbase[AW-1:0]] <= wr_data;
        end
    end

    assign used    = cptr_q - rptr_q;
    assign empty   = (used == '0);
    assign rd_data = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/intan_batch_packetizer.sv
// Frames a non-stallable per-channel sample stream into AXI4-Stream packets of cfg_batch frames,
// each frame prefixed by a 64-bit magic and 32-bit timestamp.
// Ports: aclk/aresetn; s_* sample input (no backpressure); m_* AXIS output; cfg_* session
// control; stat_* drop/error counters (saturating) and busy flag.
module intan_batch_packetizer
    import intan_pkg::*;
#(
    parameter int          N_CH       = 32,
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 256,
    parameter int          DESC_DEPTH = 8,
    parameter int          BATCH_W    = 8,
    parameter logic [63:0] MAGIC      = MAGIC_DEFAULT
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [DATA_W-1:0]  s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tuser,
    output logic [DATA_W-1:0]  m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    input  logic               cfg_enable,
    input  logic [BATCH_W-1:0] cfg_batch,
    input  logic               cfg_loopback,
    output logic [15:0]        stat_drop_cnt,
    output logic [15:0]        stat_err_cnt,
    output logic               stat_busy
);

    localparam int SAW = $clog2(FIFO_DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int IW  = $clog2(N_CH);
    localparam int DW  = $bits(desc_t);

    localparam logic [IW-1:0]     LAST_IDX = IW'(N_CH - 1);
    localparam logic [DATA_W-1:0] MAG_LO_W = DATA_W'(MAGIC[31:0]);
    localparam logic [DATA_W-1:0] MAG_HI_W = DATA_W'(MAGIC[63:32]);

    wstate_e            w_state_q, w_state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [31:0]        ts_q, ts_d;
    logic [31:0]        fts_q, fts_d;
    logic               en_q, en_d;
    logic [15:0]        drop_q, drop_d;
    logic [15:0]        err_q, err_d;
    logic [BATCH_W-1:0] fcnt_q, fcnt_d;
    logic [BATCH_W-1:0] blat_q, blat_d;
    logic               pend_q, pend_d;
    desc_t              pdesc_q, pdesc_d;

    logic               s_wr, s_rb, s_commit, s_rd, s_empty;
    logic [DATA_W-1:0]  s_wdata, s_rdata;
    logic [SAW:0]       s_used;
    logic               d_push, d_pop, d_empty;
    desc_t              d_wdata, d_rdata;
    logic [DAW:0]       d_used;

    rstate_e            r_state_q;
    logic [IW-1:0]      ridx_q;
    desc_t              cur_q;
    logic [DATA_W-1:0]  m_tdata_q;
    logic               m_tvalid_q, m_tlast_q;

    logic               sof, start, space, new_last, hs, frame_end;
    logic [31:0]        ts_cur, lb_ts, lb32;
    logic [IW-1:0]      lb_idx;
    logic [BATCH_W-1:0] beff;

    intan_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_samp (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (s_wr),
        .wr_data  (s_wdata),
        .rollback (s_rb),
        .commit   (s_commit),
        .rd_en    (s_rd),
        .rd_data  (s_rdata),
        .empty    (s_empty),
        .used     (s_used)
    );

    intan_sync_fifo #(.W(DW), .DEPTH(DESC_DEPTH)) u_desc (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (d_push),
        .wr_data  (d_wdata),
        .rollback (1'b0),
        .commit   (1'b1),
        .rd_en    (d_pop),
        .rd_data  (d_rdata),
        .empty    (d_empty),
        .used     (d_used)
    );

    // Write side: frame acceptance, timestamping, rollback of short frames.
    always_comb begin
        en_d    = cfg_enable;
        ts_cur  = (cfg_enable && !en_q) ? 32'd0 : ts_q;
        sof     = s_tvalid && s_tuser;
        // The pending descriptor still needs a slot, hence the +pend_q.
        space   = (int'(s_used) <= FIFO_DEPTH - N_CH)
               && (int'(d_used) + int'(pend_q) < DESC_DEPTH);
        w_state_d = w_state_q;
        idx_d     = idx_q;
        ts_d      = ts_cur;
        fts_d     = fts_q;
        drop_d    = drop_q;
        err_d     = err_q;
        s_wr      = 1'b0;
        s_rb      = 1'b0;
        s_commit  = 1'b0;
        start     = 1'b0;
        lb_idx    = idx_q;
        lb_ts     = fts_q;

        unique case (w_state_q)
            W_FRAME: begin
                if (s_tvalid) begin
                    if (s_tuser && idx_q != LAST_IDX) begin
                        err_d     = sat_inc(err_q);
                        s_rb      = 1'b1;
                        w_state_d = W_IDLE;
                        start     = cfg_enable;
                    end else begin
                        s_wr = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            s_commit  = 1'b1;
                            w_state_d = W_IDLE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
            end
            default: begin
                if (sof) begin
                    start     = cfg_enable;
                    w_state_d = W_IDLE;
                end
            end
        endcase

        if (start) begin
            ts_d = ts_cur + 32'd1;
            if (space) begin
                s_rb      = 1'b1;
                s_wr      = 1'b1;
                idx_d     = IW'(1);
                fts_d     = ts_cur;
                lb_idx    = '0;
                lb_ts     = ts_cur;
                w_state_d = W_FRAME;
            end else begin
                drop_d    = sat_inc(drop_q);
                w_state_d = W_SKIP;
            end
        end

        lb32    = {lb_ts[15:0], 16'(lb_idx)};
        s_wdata = cfg_loopback ? DATA_W'(lb32) : s_tdata;
    end

    // Batching: the newest frame's descriptor is held back until its last flag is known.
    always_comb begin
        beff     = (fcnt_q != '0) ? blat_q
                 : (cfg_batch == '0) ? BATCH_W'(1) : cfg_batch;
        new_last = (fcnt_q + BATCH_W'(1) == beff);
        fcnt_d   = fcnt_q;
        blat_d   = blat_q;
        pend_d   = pend_q;
        pdesc_d  = pdesc_q;
        d_push   = 1'b0;
        d_wdata  = pdesc_q;

        if (pend_q && pdesc_q.last) begin
            d_push = 1'b1;
            pend_d = 1'b0;
        end else if (pend_q && !cfg_enable && w_state_q != W_FRAME) begin
            d_push       = 1'b1;
            d_wdata.last = 1'b1;
            pend_d       = 1'b0;
            fcnt_d       = '0;
        end

        // Commits are at least N_CH cycles apart, so a pending last=1 is already gone here.
        if (s_commit) begin
            if (pend_q) begin
                d_push = 1'b1;
            end
            blat_d  = beff;
            fcnt_d  = new_last ? '0 : fcnt_q + BATCH_W'(1);
            pend_d  = 1'b1;
            pdesc_d = '{ts: fts_q, last: new_last};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            idx_q     <= '0;
            ts_q      <= '0;
            fts_q     <= '0;
            en_q      <= 1'b0;
            drop_q    <= '0;
            err_q     <= '0;
            fcnt_q    <= '0;
            blat_q    <= '0;
            pend_q    <= 1'b0;
            pdesc_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            idx_q     <= idx_d;
            ts_q      <= ts_d;
            fts_q     <= fts_d;
            en_q      <= en_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            fcnt_q    <= fcnt_d;
            blat_q    <= blat_d;
            pend_q    <= pend_d;
            pdesc_q   <= pdesc_d;
        end
    end

    // Read side: the output register always holds the beat named by r_state_q.
    always_comb begin
        hs        = m_tvalid_q && m_tready;
        frame_end = (r_state_q == R_DATA) && hs && (ridx_q == LAST_IDX);
        d_pop     = !d_empty && ((r_state_q == R_IDLE) || frame_end);
        s_rd      = hs && ((r_state_q == R_TS)
                 || (r_state_q == R_DATA && ridx_q != LAST_IDX));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q  <= R_IDLE;
            ridx_q     <= '0;
            cur_q      <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (d_pop) begin
                        cur_q      <= d_rdata;
                        m_tdata_q  <= MAG_LO_W;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b0;
                        r_state_q  <= R_MAG_LO;
                    end
                end
                R_MAG_LO: begin
                    if (hs) begin
                        m_tdata_q <= MAG_HI_W;
                        r_state_q <= R_MAG_HI;
                    end
                end
                R_MAG_HI: begin
                    if (hs) begin
                        m_tdata_q <= DATA_W'(cur_q.ts);
                        r_state_q <= R_TS;
                    end
                end
                R_TS: begin
                    if (hs) begin
                        m_tdata_q <= s_rdata;
                        ridx_q    <= '0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (hs) begin
                        if (ridx_q == LAST_IDX) begin
                            m_tlast_q <= 1'b0;
                            if (d_pop) begin
                                cur_q     <= d_rdata;
                                m_tdata_q <= MAG_LO_W;
                                r_state_q <= R_MAG_LO;
                            end else begin
                                m_tdata_q  <= '0;
                                m_tvalid_q <= 1'b0;
                                r_state_q  <= R_IDLE;
                            end
                        end else begin
                            m_tdata_q <= s_rdata;
                            ridx_q    <= ridx_q + IW'(1);
                            m_tlast_q <= cur_q.last
                                      && (ridx_q + IW'(1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign m_tdata       = m_tdata_q;
    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign stat_drop_cnt = drop_q;
    assign stat_err_cnt  = err_q;
    assign stat_busy     = (w_state_q == W_FRAME) || pend_q || (fcnt_q != '0)
                        || !s_empty || !d_empty || (r_state_q != R_IDLE);

endmodule

// File: tb/tb_intan_batch_packetizer.sv
// Directed bench for intan_batch_packetizer: two instances (deep and 8-word sample FIFO)
// share stimulus; output beats are captured per instance and compared with hand-built tables.
module tb_intan_batch_packetizer;

    localparam logic [31:0] MLO = 32'h38132A53;
    localparam logic [31:0] MHI = 32'hD7A22AAA;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tuser = 1'b0;
    logic        m_tready = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [7:0]  cfg_batch = 8'd1;
    logic        cfg_loopback = 1'b0;

    logic [31:0] a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast;
    logic [15:0] a_drop, b_drop, a_err, b_err;
    logic        a_busy, b_busy;

    logic [32:0] qa[$];
    logic [32:0] qb[$];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } vec_t;
    vec_t tbl[28];

    always #5 aclk = ~aclk;

    intan_batch_packetizer #(.N_CH(4), .FIFO_DEPTH(256)) u_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser),
        .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(m_tready), .m_tlast(a_tlast),
        .cfg_enable(cfg_enable), .cfg_batch(cfg_batch), .cfg_loopback(cfg_loopback),
        .stat_drop_cnt(a_drop), .stat_err_cnt(a_err), .stat_busy(a_busy)
    );

    intan_batch_packetizer #(.N_CH(4), .FIFO_DEPTH(8)) u_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser),
        .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(m_tready), .m_tlast(b_tlast),
        .cfg_enable(cfg_enable), .cfg_batch(cfg_batch), .cfg_loopback(cfg_loopback),
        .stat_drop_cnt(b_drop), .stat_err_cnt(b_err), .stat_busy(b_busy)
    );

    // Inputs change 1 time unit after posedge, so a negedge sample sees the coming handshake.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (a_tvalid && m_tready) qa.push_back({a_tlast, a_tdata});
            if (b_tvalid && m_tready) qb.push_back({b_tlast, b_tdata});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [32:0] qa_at(input int i);
        return (i < qa.size()) ? qa[i] : 33'bx;
    endfunction

    function automatic logic [32:0] qb_at(input int i);
        return (i < qb.size()) ? qb[i] : 33'bx;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tdata = '0;
        cfg_enable = 1'b0;
        cfg_loopback = 1'b0;
        m_tready = 1'b0;
        tick(2);
        qa.delete();
        qb.delete();
        aresetn = 1'b1;
        tick(1);
    endtask

    task automatic send_frame(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tuser = (i == 0);
            s_tdata = base + i;
            tick(1);
        end
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
    endtask

    task automatic wait_words(input string name, input bit use_b, input int n);
        for (int c = 0; c < 3000; c++) begin
            if ((use_b ? qb.size() : qa.size()) >= n) break;
            tick(1);
        end
        tick(20);
        check(name, use_b ? qb.size() : qa.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        aresetn = 1'b0;
        #1;
        check("rst tvalid", a_tvalid, 0);
        check("rst tlast", a_tlast, 0);
        check("rst tdata", a_tdata, 0);
        check("rst busy", a_busy, 0);
        check("rst drop", a_drop, 0);
        check("rst err", a_err, 0);

        // Two packets of two frames, continuous ready
        for (int f = 0; f < 4; f++) begin
            tbl[f*7]     = '{MLO, 1'b0};
            tbl[f*7 + 1] = '{MHI, 1'b0};
            tbl[f*7 + 2] = '{32'(f), 1'b0};
            for (int i = 0; i < 4; i++)
                tbl[f*7 + 3 + i] = '{32'h10 + 32'(4*f + i), (f % 2 == 1) && (i == 3)};
        end
        do_reset();
        cfg_enable = 1'b1;
        cfg_batch = 8'd2;
        m_tready = 1'b1;
        tick(1);
        for (int f = 0; f < 4; f++) send_frame(32'h10 + 32'(4*f), 4);
        wait_words("t1 count", 1'b0, 28);
        for (int i = 0; i < 28; i++)
            check($sformatf("t1 word%0d", i), qa_at(i), {tbl[i].last, tbl[i].data});
        check("t1 busy", a_busy, 0);
        check("t1 drop", a_drop, 0);

        // Stop closes a short packet
        do_reset();
        cfg_enable = 1'b1;
        cfg_batch = 8'd3;
        m_tready = 1'b1;
        tick(1);
        send_frame(32'h20, 4);
        cfg_enable = 1'b0;
        wait_words("t2 count", 1'b0, 7);
        check("t2 ts", qa_at(2), {1'b0, 32'h0});
        check("t2 w6", qa_at(5), {1'b0, 32'h22});
        check("t2 last", qa_at(6), {1'b1, 32'h23});
        check("t2 busy", a_busy, 0);

        // Stalled output, small FIFO drops whole frames
        do_reset();
        cfg_enable = 1'b1;
        cfg_batch = 8'd2;
        m_tready = 1'b0;
        tick(1);
        for (int f = 0; f < 4; f++) send_frame(32'h30 + 32'(4*f), 4);
        tick(5);
        check("t3 drop b", b_drop, 2);
        check("t3 drop a", a_drop, 0);
        check("t3 hold valid", b_tvalid, 1);
        check("t3 hold data", b_tdata, MLO);
        m_tready = 1'b1;
        wait_words("t3 count", 1'b1, 14);
        check("t3 ts0", qb_at(2), {1'b0, 32'h0});
        check("t3 s0", qb_at(3), {1'b0, 32'h30});
        check("t3 ts1", qb_at(9), {1'b0, 32'h1});
        check("t3 last", qb_at(13), {1'b1, 32'h37});

        // Short frame rolled back
        do_reset();
        cfg_enable = 1'b1;
        cfg_batch = 8'd1;
        m_tready = 1'b1;
        tick(1);
        send_frame(32'h50, 2);
        send_frame(32'h40, 4);
        wait_words("t4 count", 1'b0, 7);
        check("t4 err", a_err, 1);
        check("t4 ts", qa_at(2), {1'b0, 32'h1});
        check("t4 s0", qa_at(3), {1'b0, 32'h40});
        check("t4 last", qa_at(6), {1'b1, 32'h43});

        // Loopback pattern
        do_reset();
        cfg_enable = 1'b1;
        cfg_batch = 8'd1;
        cfg_loopback = 1'b1;
        m_tready = 1'b1;
        tick(1);
        for (int f = 0; f < 6; f++) send_frame(32'hABCD0000, 4);
        wait_words("t5 count", 1'b0, 42);
        check("t5 f0 s1", qa_at(4), {1'b0, 32'h00000001});
        check("t5 ts", qa_at(37), {1'b0, 32'h5});
        for (int i = 0; i < 4; i++)
            check($sformatf("t5 s%0d", i), qa_at(38 + i), {i == 3, 32'h00050000 + 32'(i)});

        // Asynchronous reset mid-packet
        do_reset();
        cfg_enable = 1'b1;
        cfg_batch = 8'd2;
        m_tready = 1'b1;
        tick(1);
        send_frame(32'h60, 2);
        send_frame(32'h60, 4);
        send_frame(32'h64, 4);
        for (int k = 0; k < 6; k++) begin
            m_tready = k[0];
            tick(1);
        end
        check("t6 pre err", a_err, 1);
        check("t6 pre valid", a_tvalid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6 async valid", a_tvalid, 0);
        check("t6 err clr", a_err, 0);
        check("t6 busy clr", a_busy, 0);
        tick(2);
        qa.delete();
        aresetn = 1'b1;
        m_tready = 1'b1;
        cfg_batch = 8'd1;
        tick(1);
        send_frame(32'h70, 4);
        wait_words("t6 count", 1'b0, 7);
        check("t6 mag", qa_at(0), {1'b0, MLO});
        check("t6 ts", qa_at(2), {1'b0, 32'h0});
        check("t6 last", qa_at(6), {1'b1, 32'h73});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
